execute: RTL

- Execute stage of the 5-stage RV32IM pipeline, between decode and memory.
- Registers decode outputs into the D/E pipeline register and applies forwarding muxes.
- Computes the ALU/multiply result, branch target and compare flags, all combinationally, for the memory stage to register.
- Integer divide/remainder runs as an iterative 32-step engine. It raises busy_e so the hazard unit stalls the front end.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/div_unit.sv | 114 +++++++++++
 rtl/execute.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the RV32IM pipeline: ALU op codes, forwarding selects,
// divider states and the decode-to-execute bundle.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_op_t         alu_control;
        logic            alu_src;
    } id_ex_t;

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Select 2'b11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [XLEN-1:0] fwd(
        input logic [XLEN-1:0] reg_v,
        input logic [XLEN-1:0] wb_v,
        input logic [XLEN-1:0] mem_v,
        input logic [1:0]      sel
    );
        logic [XLEN-1:0] v;
        v = reg_v;
        if (sel == FWD_WB) v = wb_v;
        else if (sel == FWD_MEM) v = mem_v;
        return v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on magnitudes; signs are reapplied once the quotient settles.
module div_unit
    import cpu_pkg::*;
#(
    parameter int DIV_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic            stall,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(DIV_STEPS);
    localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            want_rem_q, want_rem_d;
    logic            by_zero_q, by_zero_d;

    logic            is_signed, sign_a, sign_b;
    logic [XLEN:0]   rem_sh;
    logic            geq;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign is_signed = (op == ALU_DIV) || (op == ALU_REM);
    assign sign_a    = is_signed & src_a[XLEN-1];
    assign sign_b    = is_signed & src_b[XLEN-1];
    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign geq       = rem_sh >= {1'b0, dsr_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dsr_d      = dsr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        want_rem_d = want_rem_q;
        by_zero_d  = by_zero_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    quo_d      = sign_a ? -src_a : src_a;
                    dsr_d      = sign_b ? -src_b : src_b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quo_d  = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    want_rem_d = (op == ALU_REM) || (op == ALU_REMU);
                    by_zero_d  = (src_b == '0);
                    state_d    = DIV_RUN;
                end
            end
            DIV_RUN: begin
                quo_d = {quo_q[XLEN-2:0], geq};
                rem_d = geq ? rem_sh[XLEN-1:0] - dsr_q : rem_sh[XLEN-1:0];
                if (cnt_q == LAST) state_d = DIV_DONE;
                else cnt_d = cnt_q + CW'(1);
            end
            DIV_DONE: begin
                if (!stall) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
            by_zero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dsr_q      <= dsr_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            want_rem_q <= want_rem_d;
            by_zero_q  <= by_zero_d;
        end
    end

    // Divide by zero yields all ones regardless of operand signs.
    assign quo_fix = by_zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;
    assign result  = want_rem_q ? rem_fix : quo_fix;
    assign busy    = start && (state_q != DIV_DONE);
    assign done    = (state_q == DIV_DONE);

endmodule

// File: rtl/execute.sv
// Execute stage: D/E register, forwarding muxes, ALU/multiplier,
// branch target and compare flags, plus the iterative divider.
module execute
    import cpu_pkg::*;
#(
    parameter int DIV_STEPS = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus_4_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [4:0]      alu_control_d,
    input  logic            alu_src_d,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] result_w,
    input  logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] alu_result_e,
    output logic [XLEN-1:0] write_data_e,
    output logic [4:0]      rd_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [XLEN-1:0] pc_plus_4_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            zero_e,
    output logic            lt_e,
    output logic            ltu_e,
    output logic            busy_e
);

    id_ex_t de_q, de_d;

    logic [XLEN-1:0]   src_a, src_b, div_result;
    logic              div_done;
    logic [4:0]        shamt;
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, product;

    always_comb begin
        de_d = de_q;
        if (flush_e) begin
            de_d = '0;
        end else if (!stall_e) begin
            de_d.rd1         = rd1_d;
            de_d.rd2         = rd2_d;
            de_d.imm_ext     = imm_ext_d;
            de_d.pc          = pc_d;
            de_d.pc_plus_4   = pc_plus_4_d;
            de_d.rs1         = rs1_d;
            de_d.rs2         = rs2_d;
            de_d.rd          = rd_d;
            de_d.alu_control = alu_op_t'(alu_control_d);
            de_d.alu_src     = alu_src_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) de_q <= '0;
        else de_q <= de_d;
    end

    assign src_a        = fwd(de_q.rd1, result_w, alu_result_m, forward_a_e);
    assign write_data_e = fwd(de_q.rd2, result_w, alu_result_m, forward_b_e);
    assign src_b        = de_q.alu_src ? de_q.imm_ext : write_data_e;
    assign shamt        = src_b[4:0];

    // One 64-bit multiplier; operand extension picks MUL/MULH/MULHSU/MULHU signedness.
    assign mul_sa  = (de_q.alu_control == ALU_MULH) || (de_q.alu_control == ALU_MULHSU);
    assign mul_sb  = (de_q.alu_control == ALU_MULH);
    assign mul_a   = {{XLEN{mul_sa & src_a[XLEN-1]}}, src_a};
    assign mul_b   = {{XLEN{mul_sb & src_b[XLEN-1]}}, src_b};
    assign product = mul_a * mul_b;

    div_unit #(
        .DIV_STEPS(DIV_STEPS)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .start  (is_div_op(de_q.alu_control)),
        .flush  (flush_e),
        .stall  (stall_e),
        .op     (de_q.alu_control),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy_e),
        .done   (div_done),
        .result (div_result)
    );

    assign zero_e = (src_a == src_b);
    assign lt_e   = ($signed(src_a) < $signed(src_b));
    assign ltu_e  = (src_a < src_b);

    always_comb begin
        alu_result_e = '0;
        unique case (de_q.alu_control)
            ALU_ADD:    alu_result_e = src_a + src_b;
            ALU_SUB:    alu_result_e = src_a - src_b;
            ALU_AND:    alu_result_e = src_a & src_b;
            ALU_OR:     alu_result_e = src_a | src_b;
            ALU_XOR:    alu_result_e = src_a ^ src_b;
            ALU_SLT:    alu_result_e = {{(XLEN-1){1'b0}}, lt_e};
            ALU_SLTU:   alu_result_e = {{(XLEN-1){1'b0}}, ltu_e};
            ALU_SLL:    alu_result_e = src_a << shamt;
            ALU_SRL:    alu_result_e = src_a >> shamt;
            ALU_SRA:    alu_result_e = $signed(src_a) >>> shamt;
            ALU_LUI:    alu_result_e = src_b;
            ALU_MUL:    alu_result_e = product[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_result_e = product[2*XLEN-1:XLEN];
            ALU_DIV,
            ALU_DIVU,
            ALU_REM,
            ALU_REMU:   alu_result_e = div_done ? div_result : '0;
            default:    alu_result_e = '0;
        endcase
    end

    assign pc_target_e = de_q.pc + de_q.imm_ext;
    assign pc_plus_4_e = de_q.pc_plus_4;
    assign rd_e        = de_q.rd;
    assign rs1_e       = de_q.rs1;
    assign rs2_e       = de_q.rs2;

endmodule
